// File: rtl/morse_rx.sv
// morse_rx: keyed-line Morse receiver (mark/space timing to dot/dash symbols).
// Define SOS_DETECT_EN to build in the S,O,S sequence tracker driving sos_sig.
module morse_rx #(
    parameter int unsigned T1MS     = 49_999,
    parameter int unsigned DOT_MIN  = 20,
    parameter int unsigned DASH_MIN = 150,
    parameter int unsigned DASH_MAX = 600,
    parameter int unsigned CHAR_GAP = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_sig,
    input  logic       pin_in,
    output logic       sym_valid,
    output logic [4:0] sym_code,
    output logic [2:0] sym_len,
    output logic       err_sig,
    output logic       sos_sig
);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SPACE,
        EMIT,
        WAIT_HIGH
    } state_e;

    localparam logic [15:0] T1MS_W     = 16'(T1MS);
    localparam logic [9:0]  DOT_MIN_W  = 10'(DOT_MIN);
    localparam logic [9:0]  DASH_MIN_W = 10'(DASH_MIN);
    localparam logic [9:0]  DASH_MAX_W = 10'(DASH_MAX);
    localparam logic [9:0]  CHAR_GAP_W = 10'(CHAR_GAP);
    localparam logic [9:0]  MS_SAT     = 10'd1023;

    state_e      state_q, state_d;
    logic        meta_q, sync_q;
    logic [15:0] tick_q, tick_d;
    logic [9:0]  ms_q, ms_d;
    logic [4:0]  shift_q, shift_d;
    logic [2:0]  len_q, len_d;
    logic [4:0]  code_q, code_d;
    logic [2:0]  olen_q, olen_d;
    logic        err_q, err_d;
    logic        ev_push, ev_err;
    logic        is_glitch, is_dash, too_long, gap_done;

    assign is_glitch = ms_q < DOT_MIN_W;
    assign is_dash   = ms_q >= DASH_MIN_W;
    assign too_long  = ms_q > DASH_MAX_W;
    assign gap_done  = ms_q >= CHAR_GAP_W;

    // two-flop synchronizer for the asynchronous keyed line (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= pin_in;
            sync_q <= meta_q;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state plus accept/error events for the current element
    always_comb begin
        state_d = state_q;
        ev_push = 1'b0;
        ev_err  = 1'b0;
        if (!start_sig) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!sync_q) state_d = MARK;
                end
                MARK: begin
                    if (sync_q) begin
                        if (is_glitch) begin
                            state_d = (len_q != 3'd0) ? SPACE : IDLE;
                        end else if (len_q == 3'd5) begin
                            ev_err  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ev_push = 1'b1;
                            state_d = SPACE;
                        end
                    end else if (too_long) begin
                        ev_err  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
                SPACE: begin
                    if (!sync_q) state_d = MARK;
                    else if (gap_done) state_d = EMIT;
                end
                EMIT: begin
                    state_d = IDLE;
                end
                WAIT_HIGH: begin
                    if (sync_q) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ms timebase: restarts on every state change, runs only while timing a mark or space
    always_comb begin
        tick_d = tick_q;
        ms_d   = ms_q;
        if (!start_sig || (state_d != state_q)) begin
            tick_d = '0;
            ms_d   = '0;
        end else if (state_q == MARK || state_q == SPACE) begin
            if (tick_q == T1MS_W) begin
                tick_d = '0;
                if (ms_q != MS_SAT) ms_d = ms_q + 10'd1;
            end else begin
                tick_d = tick_q + 16'd1;
            end
        end
    end

    // element shift register; completed character latched on the way into EMIT
    always_comb begin
        shift_d = shift_q;
        len_d   = len_q;
        code_d  = code_q;
        olen_d  = olen_q;
        err_d   = ev_err;
        if (!start_sig || ev_err || state_q == EMIT) begin
            shift_d = '0;
            len_d   = '0;
        end else if (ev_push) begin
            shift_d = shift_q | (5'(is_dash) << len_q);
            len_d   = len_q + 3'd1;
        end
        if (start_sig && state_q == SPACE && state_d == EMIT) begin
            code_d = shift_q;
            olen_d = len_q;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            ms_q    <= '0;
            shift_q <= '0;
            len_q   <= '0;
            code_q  <= '0;
            olen_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            code_q  <= code_d;
            olen_q  <= olen_d;
            err_q   <= err_d;
        end
    end

`ifdef SOS_DETECT_EN
    localparam logic [1:0] CLS_S = 2'd1;
    localparam logic [1:0] CLS_O = 2'd2;

    logic [5:0] hist_q, hist_d, hist_nx;
    logic [1:0] cls;
    logic       sos_q, sos_d;

    // classify the emitted symbol and track the last three; S,O,S fires and clears
    always_comb begin
        cls = 2'd0;
        if (olen_q == 3'd3 && code_q == 5'b00000) cls = CLS_S;
        else if (olen_q == 3'd3 && code_q == 5'b00111) cls = CLS_O;
        hist_nx = {hist_q[3:0], cls};
        hist_d  = hist_q;
        sos_d   = 1'b0;
        if (!start_sig || ev_err) begin
            hist_d = '0;
        end else if (state_q == EMIT) begin
            if (hist_nx == {CLS_S, CLS_O, CLS_S}) begin
                sos_d  = 1'b1;
                hist_d = '0;
            end else begin
                hist_d = hist_nx;
            end
        end
    end

    // SOS tracker registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            sos_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            sos_q  <= sos_d;
        end
    end
`endif

    // outputs: pulses are masked whenever the receiver is disabled
    always_comb begin
        sym_valid = start_sig && (state_q == EMIT);
        sym_code  = code_q;
        sym_len   = olen_q;
        err_sig   = start_sig && err_q;
`ifdef SOS_DETECT_EN
        sos_sig   = start_sig && sos_q;
`else
        sos_sig   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_morse_rx.sv
// tb_morse_rx: table-driven character stimulus with a symbol scoreboard,
// plus hand sequences for reset, receiver disable and over-long marks.
module tb_morse_rx;

    localparam int CPM = 10;
`ifdef SOS_DETECT_EN
    localparam int SOS_EN = 1;
`else
    localparam int SOS_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_sig = 1'b0;
    logic       pin_in = 1'b1;
    logic       sym_valid;
    logic [4:0] sym_code;
    logic [2:0] sym_len;
    logic       err_sig;
    logic       sos_sig;

    always #5 clk = ~clk;

    morse_rx #(.T1MS(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_sig (start_sig),
        .pin_in    (pin_in),
        .sym_valid (sym_valid),
        .sym_code  (sym_code),
        .sym_len   (sym_len),
        .err_sig   (err_sig),
        .sos_sig   (sos_sig)
    );

    typedef struct {
        string      name;
        string      pat;
        int         gap_ms;
        int         exp_valid;
        logic [4:0] exp_code;
        logic [2:0] exp_len;
        int         exp_err;
        int         exp_sos;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int sos_cnt = 0;
    int rel = 0;
    int valid_rel = -1;
    int err_rel = -1;
    logic prev_valid = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // one clock; outputs sampled 1 time unit after the rising edge
    task automatic step();
        logic [7:0] e;
        @(posedge clk);
        #1;
        rel++;
        if (sym_valid) begin
            valid_cnt++;
            valid_rel = rel;
            if (exp_q.size() == 0) begin
                check("unexpected_sym_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sym_code", int'(sym_code), int'(e[7:3]));
                check("sym_len", int'(sym_len), int'(e[2:0]));
            end
        end
        if (err_sig) begin
            err_cnt++;
            err_rel = rel;
        end
        if (sos_sig) begin
            sos_cnt++;
            check("sos_after_valid", int'(prev_valid), 1);
        end
        prev_valid = sym_valid;
    endtask

    task automatic hold(input logic lvl, input int ms);
        pin_in = lvl;
        repeat (ms * CPM) step();
    endtask

    task automatic send_vec(input vec_t v);
        int  e0;
        int  s0;
        int  v0;
        int  ms;
        byte c;
        e0 = err_cnt;
        s0 = sos_cnt;
        v0 = valid_cnt;
        if (v.exp_valid != 0) exp_q.push_back({v.exp_code, v.exp_len});
        for (int i = 0; i < v.pat.len(); i++) begin
            if (i > 0) hold(1'b1, 50);
            c = v.pat[i];
            if (c == "-") ms = 300;
            else if (c == "g") ms = 10;
            else ms = 100;
            hold(1'b0, ms);
        end
        valid_rel = -1;
        rel = 0;
        hold(1'b1, v.gap_ms);
        check({v.name, ".valid_count"}, valid_cnt - v0, v.exp_valid);
        if (v.exp_valid != 0) check({v.name, ".latency"}, valid_rel, 3004);
        check({v.name, ".err_count"}, err_cnt - e0, v.exp_err);
        check({v.name, ".sos_count"}, sos_cnt - s0, v.exp_sos * SOS_EN);
        exp_q.delete();
    endtask

    initial begin
        int e0;
        int v0;

        tbl[0] = '{"S1", "...", 400, 1, 5'b00000, 3'd3, 0, 0};
        tbl[1] = '{"O", "---", 400, 1, 5'b00111, 3'd3, 0, 0};
        tbl[2] = '{"S2", "...", 400, 1, 5'b00000, 3'd3, 0, 1};
        tbl[3] = '{"glitch", ".g.", 320, 1, 5'b00000, 3'd2, 0, 0};
        tbl[4] = '{"A", ".-", 320, 1, 5'b00010, 3'd2, 0, 0};
        tbl[5] = '{"five", ".....", 320, 1, 5'b00000, 3'd5, 0, 0};
        tbl[6] = '{"six", "......", 100, 0, 5'b00000, 3'd0, 1, 0};
        tbl[7] = '{"E", ".", 320, 1, 5'b00000, 3'd1, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst.sym_valid", int'(sym_valid), 0);
        check("rst.err_sig", int'(err_sig), 0);
        check("rst.sos_sig", int'(sos_sig), 0);
        check("rst.sym_code", int'(sym_code), 0);
        check("rst.sym_len", int'(sym_len), 0);
        rst_n = 1'b1;
        start_sig = 1'b1;
        hold(1'b1, 5);

        e0 = err_cnt;
        v0 = valid_cnt;
        hold(1'b0, 100);
        hold(1'b1, 50);
        hold(1'b0, 100);
        hold(1'b1, 50);
        start_sig = 1'b0;
        hold(1'b1, 10);
        start_sig = 1'b1;
        hold(1'b1, 350);
        check("drop.valid_count", valid_cnt - v0, 0);
        check("drop.err_count", err_cnt - e0, 0);

        for (int i = 0; i < 7; i++) send_vec(tbl[i]);

        e0 = err_cnt;
        v0 = valid_cnt;
        err_rel = -1;
        rel = 0;
        hold(1'b0, 700);
        check("long.err_count", err_cnt - e0, 1);
        check("long.err_ms", err_rel / CPM, 601);
        hold(1'b1, 50);
        check("long.valid_count", valid_cnt - v0, 0);

        send_vec(tbl[7]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_rx.md
MORSE_RX -- requirements
Module: morse_rx

Interface
REQ-001 SHALL have parameter T1MS, default 49_999; clk cycles per 1 ms tick minus one (50 MHz clk).
REQ-002 SHALL have parameter DOT_MIN, default 20; minimum mark width in ms; shorter marks are glitches.
REQ-003 SHALL have parameter DASH_MIN, default 150; marks of DOT_MIN..DASH_MIN-1 ms are dots; marks of DASH_MIN..DASH_MAX ms are dashes.
REQ-004 SHALL have parameter DASH_MAX, default 600; a mark longer than this is an error.
REQ-005 SHALL have parameter CHAR_GAP, default 300; space width in ms that ends a character.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst_n, input, 1; reset, asynchronous, active-low.
REQ-008 SHALL have port start_sig, input, 1; receiver enable, level.
REQ-009 SHALL have port pin_in, input, 1; asynchronous keyed line: 0 = mark (tone), 1 = space.
REQ-010 SHALL have port sym_valid, output, 1; one-cycle pulse when a character is complete.
REQ-011 SHALL have port sym_code, output, 5; elements, first element in bit 0, 1 = dash, unused bits 0.
REQ-012 SHALL have port sym_len, output, 3; element count, 1..5.
REQ-013 SHALL have port err_sig, output, 1; one-cycle pulse on a malformed character.
REQ-014 SHALL have port sos_sig, output, 1; one-cycle pulse on detection of the sequence S,O,S.

Function
REQ-015 SHALL pass pin_in through a 2-flop synchronizer (flops reset to 1); all decoding uses the synchronized value.
REQ-016 SHALL generate a 1 ms tick from a 16-bit counter wrapping at T1MS; the counter runs only in MARK/SPACE and clears on every state change.
REQ-017 SHALL count ms in a 10-bit width counter saturating at 1023, cleared on state entry.
REQ-018 SHALL implement states IDLE, MARK, SPACE, EMIT, WAIT_HIGH.
REQ-019 IDLE: sync line 0 -> MARK.
REQ-020 MARK, line returns 1: width < DOT_MIN -> glitch, element discarded, -> SPACE if len>0 else IDLE; dot -> shift 0; dash -> shift 1; then -> SPACE.
REQ-021 MARK, width exceeds DASH_MAX while the line is still 0: err_sig pulse, character discarded -> WAIT_HIGH.
REQ-022 Element accepted with len already 5: err_sig pulse, character discarded -> IDLE.
REQ-023 SPACE: line 0 before CHAR_GAP -> MARK; width reaches CHAR_GAP -> EMIT.
REQ-024 EMIT (one cycle): sym_valid=1 with sym_code/sym_len; clear the shift register -> IDLE.
REQ-025 sym_code/sym_len SHALL hold their value until the next EMIT.
REQ-026 WAIT_HIGH: line 1 -> IDLE.
REQ-027 Latency: sym_valid SHALL assert exactly 1 cycle after the space counter reaches CHAR_GAP.
REQ-028 start_sig=0 SHALL force IDLE, clear counters, the shift register and the SOS tracker, and suppress all pulses; a character in progress SHALL be abandoned without emit or error.
REQ-029 S is sym_len=3 with sym_code=00000; O is sym_len=3 with sym_code=00111.

Reset
REQ-030 On rst_n low: state IDLE; all counters 0; sym_valid, err_sig and sos_sig 0; sym_code 0; sym_len 0; SOS tracker cleared.

Configuration
REQ-031 Macro SOS_DETECT_EN defined: SHALL include a tracker of the last three emitted symbols; sos_sig pulses 1 cycle after the sym_valid completing S,O,S.
REQ-032 After an SOS detection, the tracker SHALL clear (no overlap); err_sig SHALL also clear it.
REQ-033 Macro SOS_DETECT_EN undefined: the tracker SHALL be absent and sos_sig tied 0.

Verification (T1MS reduced to 9 for simulation)
REQ-034 Send three 100 ms marks separated by 50 ms spaces, then a 400 ms space -> one sym_valid with sym_len=3 and sym_code=00000; err_sig stays 0.
REQ-035 Send three 300 ms marks separated by 50 ms spaces, then a 400 ms space -> sym_len=3, sym_code=00111.
REQ-036 Send S, O, S with 400 ms gaps, SOS_DETECT_EN defined -> sos_sig pulses once, 1 cycle after the third sym_valid; with the macro undefined, sos_sig stays 0.
REQ-037 Send a 10 ms glitch between two 100 ms dots -> sym_len=2, sym_code=00000.
REQ-038 Send a 700 ms mark -> err_sig pulses at 601 ms, no sym_valid follows, and the FSM returns to IDLE after the line rises; send six dots -> err_sig on the sixth.
REQ-039 Drop start_sig after two dots -> no sym_valid and no err_sig; a subsequent S decodes correctly.
